// File: rtl/elm_neuron_mac_if.sv
// rtl/elm_neuron_mac_if.sv - activation, weight-memory and result signals of one ELM hidden neuron
interface elm_neuron_mac_if #(
  parameter int dataWidth    = 16,
  parameter int addressWidth = 10
);
  logic [dataWidth-1:0]  myinput;
  logic                  myinputValid;
  logic [dataWidth-1:0]  bias;
  logic                  ren;
  logic [addressWidth:0] raddr;
  logic [dataWidth-1:0]  wout;
  logic [dataWidth-1:0]  out;
  logic                  outvalid;

  // master: upstream activation source together with the weight memory
  modport master (
    output myinput, myinputValid, bias, wout,
    input  ren, raddr, out, outvalid
  );

  modport slave (
    input  myinput, myinputValid, bias, wout,
    output ren, raddr, out, outvalid
  );
endinterface

// File: rtl/elm_neuron_mac.sv
// rtl/elm_neuron_mac.sv - neuron multiply-accumulate with bias add and saturation; RELU_EN enables ReLU output
module elm_neuron_mac #(
  parameter int numWeight      = 784,
  parameter int addressWidth   = 10,
  parameter int dataWidth      = 16,
  parameter int weightIntWidth = 4
) (
  input logic             clk,
  input logic             rst,
  elm_neuron_mac_if.slave bus
);

  localparam int frac_bits = dataWidth - weightIntWidth;
  localparam int acc_width = 2 * dataWidth;
  localparam int cnt_width = $clog2(numWeight + 1);
  localparam int last_idx  = numWeight - 1;

  localparam logic signed [acc_width-1:0] acc_max = {1'b0, {(acc_width-1){1'b1}}};
  localparam logic signed [acc_width-1:0] acc_min = {1'b1, {(acc_width-1){1'b0}}};
  localparam logic signed [acc_width-1:0] lim_max =
    {{(acc_width-dataWidth+1){1'b0}}, {(dataWidth-1){1'b1}}};
  localparam logic signed [acc_width-1:0] lim_min =
    {{(acc_width-dataWidth+1){1'b1}}, {(dataWidth-1){1'b0}}};
  localparam logic [dataWidth-1:0] out_max = {1'b0, {(dataWidth-1){1'b1}}};
  localparam logic [dataWidth-1:0] out_min = {1'b1, {(dataWidth-1){1'b0}}};

  typedef enum logic [1:0] {FILL, DRAIN, OUT} state_t;

  state_t                       state;
  logic                         accept;
  logic [addressWidth:0]        raddr_r;
  logic signed [dataWidth-1:0]  in_d;
  logic                         in_valid;
  logic signed [acc_width-1:0]  mul_r;
  logic                         mul_valid;
  logic signed [acc_width-1:0]  sum;
  logic [cnt_width-1:0]         beat_cnt;
  logic [dataWidth-1:0]         out_r;
  logic                         outvalid_r;

  logic signed [acc_width-1:0]  sum_acc;
  logic signed [acc_width-1:0]  bias_sh;
  logic signed [acc_width-1:0]  t_sum;
  logic signed [acc_width-1:0]  t_shr;
  logic [dataWidth-1:0]         out_next;

  function automatic logic signed [acc_width-1:0] sat_add(
    input logic signed [acc_width-1:0] a,
    input logic signed [acc_width-1:0] b
  );
    logic signed [acc_width-1:0] s;
    s = a + b;
    if ((a[acc_width-1] == b[acc_width-1]) && (s[acc_width-1] != a[acc_width-1]))
      s = a[acc_width-1] ? acc_min : acc_max;
    return s;
  endfunction

  // Weight read is issued in the same cycle the activation is accepted.
  assign accept       = (state == FILL) && bus.myinputValid && !rst;
  assign bus.ren      = accept;
  assign bus.raddr    = raddr_r;
  assign bus.out      = out_r;
  assign bus.outvalid = outvalid_r;

  always_comb begin
    sum_acc  = sat_add(sum, mul_r);
    bias_sh  = acc_width'($signed(bus.bias)) <<< frac_bits;
    t_sum    = sat_add(sum, bias_sh);
    t_shr    = t_sum >>> frac_bits;
    out_next = t_shr[dataWidth-1:0];
    if (t_shr > lim_max)
      out_next = out_max;
    else if (t_shr < lim_min)
      out_next = out_min;
`ifdef RELU_EN
    if (t_shr[acc_width-1])
      out_next = '0;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= FILL;
      raddr_r    <= '0;
      in_d       <= '0;
      in_valid   <= 1'b0;
      mul_r      <= '0;
      mul_valid  <= 1'b0;
      sum        <= '0;
      beat_cnt   <= '0;
      out_r      <= '0;
      outvalid_r <= 1'b0;
    end else begin
      outvalid_r <= 1'b0;
      in_valid   <= accept;
      mul_valid  <= in_valid;

      if (accept) begin
        in_d <= bus.myinput;
        if (raddr_r == last_idx[addressWidth:0]) begin
          raddr_r <= '0;
          state   <= DRAIN;
        end else begin
          raddr_r <= raddr_r + 1'b1;
        end
      end

      if (in_valid)
        mul_r <= acc_width'(in_d) * acc_width'($signed(bus.wout));

      if (state == OUT) begin
        sum        <= '0;
        beat_cnt   <= '0;
        out_r      <= out_next;
        outvalid_r <= 1'b1;
        state      <= FILL;
      end else if (mul_valid) begin
        sum <= sum_acc;
        // The beat count, not the address, decides completion so in-flight products are never lost.
        if (beat_cnt == last_idx[cnt_width-1:0]) begin
          beat_cnt <= '0;
          state    <= OUT;
        end else begin
          beat_cnt <= beat_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_elm_neuron_mac.sv
// tb/tb_elm_neuron_mac.sv - directed bench for elm_neuron_mac with a one-cycle weight memory model
module tb_elm_neuron_mac;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  int   pulse_cnt;
  int   pulses_before;
  logic [15:0] mem [0:3];

  elm_neuron_mac_if #(.dataWidth(16), .addressWidth(10)) bus ();

  elm_neuron_mac #(
    .numWeight(4),
    .addressWidth(10),
    .dataWidth(16),
    .weightIntWidth(4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk)
    if (bus.ren) bus.wout <= mem[bus.raddr[1:0]];

  always @(negedge clk)
    if (bus.outvalid === 1'b1) pulse_cnt = pulse_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic load_weights(input logic [15:0] w);
    for (int i = 0; i < 4; i++) mem[i] = w;
  endtask

  task automatic run_vec(input string tag, input logic [15:0] x, input int gap,
                         input bit drain, input logic [15:0] exp_out);
    int n;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk({tag, "_raddr"}, 32'(bus.raddr), i);
      bus.myinput      = x;
      bus.myinputValid = 1'b1;
      #1;
      chk({tag, "_ren"}, 32'(bus.ren), 1);
      if (i < 3)
        for (int g = 0; g < gap; g++) begin
          @(negedge clk);
          bus.myinputValid = 1'b0;
        end
    end
    n = 0;
    while (n < 12) begin
      @(negedge clk);
      n++;
      bus.myinputValid = 1'b0;
      if (bus.outvalid === 1'b1) break;
      if (drain && n <= 3) begin
        bus.myinput      = 16'h7000;
        bus.myinputValid = 1'b1;
        #1;
        chk({tag, "_drain_ren"}, 32'(bus.ren), 0);
        chk({tag, "_drain_raddr"}, 32'(bus.raddr), 0);
      end
    end
    chk({tag, "_latency"}, n, 4);
    chk({tag, "_out"}, 32'(bus.out), 32'(exp_out));
    @(negedge clk);
    chk({tag, "_pulse_end"}, 32'(bus.outvalid), 0);
    chk({tag, "_out_hold"}, 32'(bus.out), 32'(exp_out));
    chk({tag, "_raddr_wrap"}, 32'(bus.raddr), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    checks           = 0;
    failures         = 0;
    pulse_cnt        = 0;
    rst              = 1'b1;
    bus.myinput      = 16'h0000;
    bus.myinputValid = 1'b1;
    bus.bias         = 16'h0000;
    bus.wout         = 16'h0000;
    load_weights(16'h0800);

    repeat (3) @(negedge clk);
    #1;
    chk("reset_ren", 32'(bus.ren), 0);
    chk("reset_raddr", 32'(bus.raddr), 0);
    chk("reset_out", 32'(bus.out), 0);
    chk("reset_outvalid", 32'(bus.outvalid), 0);
    bus.myinputValid = 1'b0;
    rst = 1'b0;

    bus.bias = 16'h0400;
    run_vec("basic", 16'h1000, 0, 1'b0, 16'h2400);
    run_vec("gap", 16'h1000, $urandom_range(1, 3), 1'b0, 16'h2400);
    run_vec("gap3", 16'h1000, 3, 1'b0, 16'h2400);

    load_weights(16'h7000);
    bus.bias = 16'h7000;
    run_vec("sat_pos", 16'h7000, 0, 1'b0, 16'h7FFF);
    load_weights(16'h9000);
    run_vec("sat_neg", 16'h7000, 0, 1'b0, 16'h8000);

    load_weights(16'hF000);
    bus.bias = 16'h0000;
`ifdef RELU_EN
    run_vec("negative", 16'h1000, 0, 1'b0, 16'h0000);
`else
    run_vec("negative", 16'h1000, 0, 1'b0, 16'hC000);
`endif

    load_weights(16'h0800);
    bus.bias = 16'h0400;
    @(negedge clk);
    bus.myinput      = 16'h1000;
    bus.myinputValid = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("abort_raddr_pre", 32'(bus.raddr), 2);
    bus.myinputValid = 1'b0;
    rst              = 1'b1;
    pulses_before    = pulse_cnt;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_raddr_reset", 32'(bus.raddr), 0);
    repeat (8) @(negedge clk);
    chk("abort_no_pulse", pulse_cnt, pulses_before);
    run_vec("after_reset", 16'h1000, 0, 1'b0, 16'h2400);

    run_vec("drain_pulse", 16'h1000, 0, 1'b1, 16'h2400);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/elm_neuron_mac.md
Name: elm_neuron_mac

Overview:
- Hidden-layer neuron datapath that sits directly downstream of a per-neuron weight memory.
- Accepts a stream of input activations and drives the weight memory read port (ren/raddr) in lockstep.
- Multiplies each activation by its returned weight and accumulates. After numWeight terms, adds bias and emits one saturated fixed-point result with a one-cycle valid pulse.

Parameters:
- numWeight, 784, number of activation/weight pairs per output.
- addressWidth, 10, weight memory address parameter; raddr is addressWidth+1 bits wide.
- dataWidth, 16, signed width of activation, weight, bias and output.
- weightIntWidth, 4, integer bits including sign; fracBits = dataWidth-weightIntWidth (12 by default).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous active-high reset.
- myinput  in  dataWidth  signed activation.
- myinputValid  in  1  activation qualifier.
- bias  in  dataWidth  signed bias, same Q format as activations; sampled in the bias-add cycle.
- ren  out  1  weight memory read enable.
- raddr  out  addressWidth+1  weight memory read address.
- wout  in  dataWidth  weight read data; valid one cycle after ren.
- out  out  dataWidth  signed neuron result.
- outvalid  out  1  one-cycle pulse qualifying out.

Behaviour:
- Reset: synchronous, active-high. Clears ren=0, raddr=0, out=0, outvalid=0, sum=0, all counters, pipeline valids and state=FILL. Reset mid-vector discards the partial sum; no outvalid is produced.
- States:
  - FILL: accepting activations.
  - DRAIN: waiting for the pipeline to empty; activations ignored.
  - OUT: bias add.
- FILL behaviour:
  - ren = myinputValid, combinational.
  - raddr is a register holding the current weight index.
  - On each accepted input, raddr increments and myinput is registered into in_d to align with wout one cycle later.
  - After the numWeight-th accepted input: raddr wraps to 0 and state goes to DRAIN.
- DRAIN and OUT behaviour:
  - ren = 0; myinputValid is ignored (no address advance, no accumulation).
  - Upstream must not send the next vector until the cycle after outvalid.
- Pipeline, with the last valid input at cycle T:
  - T+1: wout and in_d valid.
  - T+2: mul_r = signed in_d*wout, 2*dataWidth bits, with mul_valid.
  - T+3: sum holds the final accumulation.
  - T+4: out and outvalid=1.
  - outvalid is high for exactly one cycle; out holds its value until the next result or reset.
- Accumulation:
  - sum is 2*dataWidth signed.
  - Each mul_valid adds mul_r with saturation: if both operands share a sign and the result sign differs, clamp to max positive or min negative.
  - A counter of mul_valid beats reaching numWeight triggers OUT.
- OUT (one cycle):
  - t = sat(sum + (sign-extended bias << fracBits)).
  - out = t >>> fracBits, saturated to dataWidth signed (0x7FFF / 0x8000).
  - sum and the beat counter clear in the same cycle; state returns to FILL.
- Gaps in myinputValid are allowed. The result depends only on the sequence of accepted inputs, not on their timing.
- The output is the rounding-free arithmetic shift (floor).

Optional Feature:
- Macro RELU_EN.
- Defined: the OUT stage applies ReLU after saturation; a negative result gives out=0. Latency is unchanged.
- Undefined: linear saturated output.

Test Plan (numWeight=4, defaults otherwise; weight memory model returns mem[raddr] one cycle after ren):
- Inputs 0x1000 (1.0) ×4 back-to-back, weights 0x0800 (0.5), bias 0x0400 -> out=0x2400 (2.25); outvalid a single pulse 4 cycles after the last input.
- Same vector with 1-3 idle cycles between inputs -> identical out=0x2400; raddr sequence 0,1,2,3, then 0 for the next vector.
- Inputs 0x7000, weights 0x7000, bias 0x7000 -> out=0x7FFF. Weights 0x9000, same inputs -> out=0x8000.
- Weights 0xF000 (-1.0), inputs 0x1000, bias 0 -> out=0xC000 without RELU_EN; out=0x0000 with RELU_EN.
- rst asserted after 2 inputs, then a full fresh vector of the first case -> out=0x2400; no outvalid for the aborted vector; raddr restarts at 0.
- myinputValid pulsed during DRAIN -> ignored: ren stays 0, raddr unchanged, result unchanged.
